// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGGER_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_PLLRST  = 3'd0,
    ST_WAIT    = 3'd1,
    ST_STABLE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the oscillator domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Resets the PLL, waits for a stable lock, then releases the clock-domain resets in stagger.
//   state   | meaning
//   PLLRST  | PLL held in reset, all domains in reset
//   WAIT    | PLL running, waiting for synchronized lock (bounded by timeout)
//   STABLE  | lock seen, counting consecutive locked cycles
//   RELEASE | domain resets released one by one, STAGGER_CYCLES apart
//   RUN     | all domains out of reset, ready asserted
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic [2:0] domain_rst,
  output logic       ready,
  output logic [7:0] relock_cnt,
  output logic [7:0] timeout_cnt
);

  localparam logic [15:0] C_RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] C_TMO_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] C_STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] C_STAGGER     = 16'(STAGGER_CYCLES);
  localparam logic [15:0] C_REL_LAST    = 16'(2 * STAGGER_CYCLES - 1);

  seq_state_t  r_state;
  logic [15:0] r_cnt;
  logic        r_pll_rst;
  logic [2:0]  r_domain_rst;
  logic        r_ready;
  logic [7:0]  r_relock_cnt;
  logic [7:0]  r_timeout_cnt;

  seq_state_t  w_next_state;
  logic [15:0] w_next_cnt;
  logic        w_lock_s;
  logic        w_relock_evt;
  logic        w_timeout_evt;
  logic [2:0]  w_next_domain_rst;

  sync_2ff u_sync_lock (
    .i_clk (clk_25mhz),
    .i_rst (rst),
    .i_d   (locked),
    .o_q   (w_lock_s)
  );

  always_comb begin
    w_next_state  = r_state;
    w_relock_evt  = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      ST_PLLRST: begin
        if (r_cnt == C_RST_LAST) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (force_relock) begin
          w_next_state = ST_PLLRST;
        end else if (w_lock_s) begin
          w_next_state = ST_STABLE;
        end else if (r_cnt == C_TMO_LAST) begin
          w_next_state  = ST_PLLRST;
          w_timeout_evt = 1'b1;
        end
      end
      ST_STABLE: begin
        if (force_relock) w_next_state = ST_PLLRST;
        else if (!w_lock_s) w_next_state = ST_WAIT;
        else if (r_cnt == C_STABLE_LAST) w_next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (force_relock || !w_lock_s) begin
          w_next_state = ST_PLLRST;
          w_relock_evt = 1'b1;
        end else if (r_cnt == C_REL_LAST) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (force_relock || !w_lock_s) begin
          w_next_state = ST_PLLRST;
          w_relock_evt = 1'b1;
        end
      end
      default: w_next_state = ST_PLLRST;
    endcase

    // RUN has no timed exit, so its counter parks instead of wrapping.
    if (w_next_state != r_state) w_next_cnt = 16'd0;
    else if (r_state == ST_RUN)  w_next_cnt = r_cnt;
    else                         w_next_cnt = r_cnt + 16'd1;
  end

  // Outputs are decoded from the upcoming state so the registered values line up with it.
  always_comb begin
    w_next_domain_rst = 3'b111;
    case (w_next_state)
      ST_RELEASE: w_next_domain_rst = {1'b1, (w_next_cnt < C_STAGGER), 1'b0};
      ST_RUN:     w_next_domain_rst = 3'b000;
      default:    w_next_domain_rst = 3'b111;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_state       <= ST_PLLRST;
      r_cnt         <= 16'd0;
      r_pll_rst     <= 1'b1;
      r_domain_rst  <= 3'b111;
      r_ready       <= 1'b0;
      r_relock_cnt  <= 8'd0;
      r_timeout_cnt <= 8'd0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_pll_rst    <= (w_next_state == ST_PLLRST);
      r_domain_rst <= w_next_domain_rst;
      r_ready      <= (w_next_state == ST_RUN);
      if (w_relock_evt && (r_relock_cnt != 8'hFF))
        r_relock_cnt <= r_relock_cnt + 8'd1;
      if (w_timeout_evt && (r_timeout_cnt != 8'hFF))
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign domain_rst  = r_domain_rst;
  assign ready       = r_ready;
  assign relock_cnt  = r_relock_cnt;
  assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters (4/32/8/2).
module tb_pll_lock_sequencer;

  logic       clk_25mhz = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int failures = 0;

  int n_pll, f110, f100, f000, frdy;
  int rises, r1, r2, n_rdy, n_pr;
  logic prev;

  pll_lock_sequencer #(
    .RST_CYCLES     (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .STAGGER_CYCLES (2)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .rst          (rst),
    .locked       (locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .relock_cnt   (relock_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic wait_110(input string tag);
    for (int w = 0; w < 40 && domain_rst != 3'b110; w++) cyc(1);
    chk(tag, 32'(domain_rst), 32'd6);
  endtask

  initial begin
    // Startup with lock already present
    cyc(1);
    locked = 1'b1;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_domain", 32'(domain_rst), 32'd7);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_relock", 32'(relock_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout_cnt), 32'd0);
    n_pll = 0; f110 = -1; f100 = -1; f000 = -1; frdy = -1;
    for (int k = 0; k <= 24; k++) begin
      if (pll_rst) n_pll++;
      if (domain_rst == 3'b110 && f110 < 0) f110 = k;
      if (domain_rst == 3'b100 && f100 < 0) f100 = k;
      if (domain_rst == 3'b000 && f000 < 0) f000 = k;
      if (ready && frdy < 0) frdy = k;
      if (k < 24) cyc(1);
    end
    chk("start_pll_rst_len", 32'(n_pll), 32'd4);
    chk("start_first_110", 32'(f110), 32'd13);
    chk("start_first_100", 32'(f100), 32'd15);
    chk("start_first_000", 32'(f000), 32'd17);
    chk("start_first_ready", 32'(frdy), 32'd17);

    // Lock loss in RUN
    locked = 1'b0;
    cyc(2);
    chk("drop_not_early", 32'(domain_rst), 32'd0);
    cyc(1);
    chk("drop_domain", 32'(domain_rst), 32'd7);
    chk("drop_pll_rst", 32'(pll_rst), 32'd1);
    chk("drop_ready", 32'(ready), 32'd0);
    chk("drop_relock", 32'(relock_cnt), 32'd1);
    locked = 1'b1;
    cyc(16);
    chk("relock_ready_early", 32'(ready), 32'd0);
    cyc(1);
    chk("relock_ready", 32'(ready), 32'd1);
    chk("relock_domain", 32'(domain_rst), 32'd0);

    // Lock loss and force_relock hitting the same decision cycle
    locked = 1'b0;
    cyc(2);
    force_relock = 1'b1;
    cyc(1);
    force_relock = 1'b0;
    locked = 1'b1;
    chk("both_domain", 32'(domain_rst), 32'd7);
    chk("both_relock", 32'(relock_cnt), 32'd2);
    cyc(3);
    chk("both_relock_hold", 32'(relock_cnt), 32'd2);

    // Reset during RELEASE
    wait_110("wait_release");
    rst = 1'b1;
    cyc(1);
    chk("midrst_domain", 32'(domain_rst), 32'd7);
    chk("midrst_pll_rst", 32'(pll_rst), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_relock", 32'(relock_cnt), 32'd0);
    chk("midrst_timeout", 32'(timeout_cnt), 32'd0);

    // No lock for 100 cycles
    locked = 1'b0;
    cyc(2);
    rst = 1'b0;
    prev = pll_rst; rises = 0; r1 = -1; r2 = -1; n_rdy = 0;
    for (int k = 1; k <= 100; k++) begin
      cyc(1);
      if (pll_rst && !prev) begin
        rises++;
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      prev = pll_rst;
      if (ready) n_rdy++;
    end
    chk("tmo_rises", 32'(rises), 32'd2);
    chk("tmo_first_repulse", 32'(r1), 32'd36);
    chk("tmo_second_repulse", 32'(r2), 32'd72);
    chk("tmo_ready_cycles", 32'(n_rdy), 32'd0);
    chk("tmo_count", 32'(timeout_cnt), 32'd2);

    // Lock glitch during STABLE
    rst = 1'b1;
    locked = 1'b1;
    cyc(3);
    rst = 1'b0;
    n_pr = 0; f110 = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (k == 7) locked = 1'b0;
      if (k == 10) locked = 1'b1;
      if (k >= 4 && pll_rst) n_pr++;
      if (domain_rst == 3'b110 && f110 < 0) f110 = k;
    end
    chk("glitch_no_pll_rst", 32'(n_pr), 32'd0);
    chk("glitch_first_110", 32'(f110), 32'd21);
    chk("glitch_relock", 32'(relock_cnt), 32'd0);

    // force_relock in WAIT restarts silently; in PLLRST it is ignored
    rst = 1'b1;
    locked = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(6);
    force_relock = 1'b1;
    cyc(1);
    force_relock = 1'b0;
    chk("wait_force_pll_rst", 32'(pll_rst), 32'd1);
    chk("wait_force_relock", 32'(relock_cnt), 32'd0);
    chk("wait_force_timeout", 32'(timeout_cnt), 32'd0);
    cyc(1);
    force_relock = 1'b1;
    cyc(1);
    force_relock = 1'b0;
    cyc(1);
    chk("pllrst_force_hold", 32'(pll_rst), 32'd1);
    cyc(1);
    chk("pllrst_force_ignored", 32'(pll_rst), 32'd0);
    chk("pllrst_force_relock", 32'(relock_cnt), 32'd0);

    // 300 forced relocks from RELEASE
    rst = 1'b1;
    locked = 1'b1;
    cyc(3);
    rst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      wait_110("sat_wait_release");
      force_relock = 1'b1;
      cyc(1);
      force_relock = 1'b0;
      if (i == 100) chk("sat_mid", 32'(relock_cnt), 32'd100);
      if (i == 255) chk("sat_at_255", 32'(relock_cnt), 32'd255);
    end
    chk("sat_final", 32'(relock_cnt), 32'd255);
    chk("sat_timeout", 32'(timeout_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles that pll_rst is held per PLL reset attempt (minimum 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: cycles waited for lock before re-resetting the PLL (at most 65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before any reset release.
REQ-004 SHALL have parameter STAGGER_CYCLES, default 8: spacing in cycles between successive domain reset releases (minimum 1).
REQ-005 SHALL have port clk_25mhz, input, 1 bit: the single clock, the free-running 25 MHz board oscillator, not a PLL output.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port locked, input, 1 bit: PLL LOCK, asynchronous to clk_25mhz.
REQ-008 SHALL have port force_relock, input, 1 bit: single-cycle request to restart the PLL.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives the PLL RST pin.
REQ-010 SHALL have port domain_rst, output, 3 bits: active-high resets for the 25, 125 and 250 MHz domains, in bit order 0, 1, 2.
REQ-011 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port relock_cnt, output, 8 bits: count of lock losses and forced relocks taken from RUN or RELEASE, saturating at 255.
REQ-013 SHALL have port timeout_cnt, output, 8 bits: count of WAIT timeouts, saturating at 255.

Function
REQ-014 SHALL pass locked through a 2-flop synchronizer to produce lock_s; all decisions SHALL use lock_s only.
REQ-015 SHALL register every output and decode no output combinationally from inputs.
REQ-016 SHALL implement the state machine PLLRST, WAIT, STABLE, RELEASE, RUN with a single 16-bit counter cnt that clears on every state change.
REQ-017 PLLRST: SHALL hold pll_rst=1 and domain_rst=3'b111; when cnt==RST_CYCLES-1, SHALL move to WAIT.
REQ-018 WAIT: pll_rst=0; lock_s=1 SHALL move to STABLE; otherwise cnt==LOCK_TIMEOUT-1 SHALL move to PLLRST and increment timeout_cnt.
REQ-019 STABLE: lock_s=0 SHALL return to WAIT without asserting pll_rst; cnt==STABLE_CYCLES-1 SHALL move to RELEASE.
REQ-020 RELEASE: domain_rst[0] SHALL deassert on the first RELEASE cycle, domain_rst[1] at cnt==STAGGER_CYCLES, and domain_rst[2] at cnt==2*STAGGER_CYCLES, which SHALL also be the cycle of transition to RUN.
REQ-021 RUN: SHALL hold domain_rst=3'b000 and ready=1.
REQ-022 In RELEASE or RUN, lock_s=0 or force_relock=1 SHALL cause the next state to be PLLRST, with domain_rst=3'b111, ready=0 and pll_rst=1 from the following edge, and SHALL increment relock_cnt once even if both events occur in the same cycle.
REQ-023 In WAIT or STABLE, force_relock SHALL move to PLLRST without incrementing either counter; in PLLRST, force_relock SHALL be ignored.
REQ-024 Latency from a falling locked edge to domain_rst=3'b111 SHALL be at most 3 clk_25mhz cycles in RELEASE or RUN.
REQ-025 Saturated counters SHALL hold at 255 and SHALL clear only by rst.

Reset
REQ-026 On rst=1 the block SHALL enter PLLRST and set cnt=0, synchronizer flops=0, pll_rst=1, domain_rst=3'b111, ready=0, relock_cnt=0 and timeout_cnt=0.
REQ-027 rst asserted mid-sequence (for example during RELEASE) SHALL take priority over all other events and restart the full sequence.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-029 The synchronizer SHALL be sub-module sync_2ff, and there SHALL be no other sub-modules.

Verification (parameters RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, STAGGER_CYCLES=2)
REQ-030 Release rst with locked=1 held -> pll_rst high for exactly 4 cycles; domain_rst goes 110, 100, 000 two cycles apart; ready=1 together with domain_rst=000.
REQ-031 Hold locked=0 for 100 cycles -> pll_rst re-pulses after every 32 WAIT cycles; timeout_cnt=2 after 2 timeouts; ready stays 0.
REQ-032 Glitch locked low for 3 cycles during STABLE -> return to WAIT, no pll_rst pulse, full 8-cycle stability count restarts, relock_cnt=0.
REQ-033 Drop locked in RUN -> domain_rst=111 within 3 cycles, relock_cnt=1, full sequence repeats; force_relock in the same cycle as the drop -> relock_cnt still increments by 1 only.
REQ-034 Assert rst during RELEASE with domain_rst=110 -> next cycle shows state PLLRST, domain_rst=111 and both counters 0.
REQ-035 Force 300 lock losses -> relock_cnt saturates at 255 with no wrap.
